mod_updown_counter: RTL

//  Parametrised modulo counter: up/down, parallel load, sync clear, auto-reload or one-shot.

---
 rtl/mod_updown_counter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter: parallel load, sync clear, auto-reload or one-shot halt.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module mod_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 9,
    parameter int unsigned ONE_SHOT  = 0,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] cnt_step;
    logic             wrap_d;
    logic             done_q, done_d;
    logic             step;
    logic             at_term;
    logic             next_term;

`ifdef COUNTER_PRESCALE_EN
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    always_comb begin
        ps_d = ps_q;
        if (sync_clr || load) begin
            ps_d = '0;
        end else if (enable) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    assign step = enable && (ps_q == PS_LAST);
`else
    assign step = enable;
`endif

    assign at_term   = up_dn ? (count == MAX_CNT) : (count == '0);
    assign cnt_step  = up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
    assign next_term = up_dn ? (cnt_step == MAX_CNT) : (cnt_step == '0);
    assign tc        = at_term;

    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        done_d  = done_q;
        state_d = state_q;
        if (sync_clr) begin
            count_d = up_dn ? '0 : MAX_CNT;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (load) begin
            count_d = (load_value > MAX_CNT) ? MAX_CNT : load_value;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (step && (state_q == RUN)) begin
            if (ONE_SHOT != 0) begin
                // A step from a loaded terminal value halts in place.
                if (at_term) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    count_d = cnt_step;
                    if (next_term) begin
                        state_d = HALT;
                        done_d  = 1'b1;
                    end
                end
            end else if (at_term) begin
                count_d = up_dn ? '0 : MAX_CNT;
                wrap_d  = 1'b1;
            end else begin
                count_d = cnt_step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= MAX_CNT;
            wrap    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= RUN;
        end else begin
            count   <= count_d;
            wrap    <= wrap_d;
            done_q  <= done_d;
            state_q <= state_d;
        end
    end

    assign done = (ONE_SHOT != 0) ? done_q : 1'b0;

endmodule
